// File: rtl/display_pkg.sv
// Shared types and constants for the display scheduler: FSM states, source codes, display word.
package display_pkg;

  localparam int unsigned HEX_W = 8;
  localparam int unsigned SPR_W = 7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHOW_INFO = 2'd1,
    SHOW_ERR  = 2'd2
  } disp_state_t;

  localparam logic [1:0] SRC_LIVE = 2'd0;
  localparam logic [1:0] SRC_INFO = 2'd1;
  localparam logic [1:0] SRC_ERR  = 2'd2;

  typedef struct packed {
    logic [HEX_W-1:0] hex;
    logic [SPR_W-1:0] spr;
  } disp_word_t;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that stops at zero; zero flags an expired count.
module hold_timer #(
  parameter int unsigned MAX_COUNT = 1,
  localparam int unsigned W = $clog2(MAX_COUNT + 1)
) (
  input  logic         slow_clock,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge slow_clock) begin
    if (RESET) count_q <= '0;
    else       count_q <= count_d;
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the 7-segment display between the live readout, info and error messages.
// DISPLAY_BLINK_EN: when defined, error messages blink against the live value.
module display_scheduler
  import display_pkg::*;
#(
  parameter int unsigned HOLD_TICKS  = 2000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic             slow_clock,
  input  logic             RESET,
  input  logic [HEX_W-1:0] live_hex,
  input  logic [SPR_W-1:0] live_spr,
  input  logic             err_req,
  input  logic [HEX_W-1:0] err_hex,
  input  logic [SPR_W-1:0] err_spr,
  output logic             err_ack,
  input  logic             info_req,
  input  logic [HEX_W-1:0] info_hex,
  input  logic [SPR_W-1:0] info_spr,
  output logic             info_ack,
  output logic [HEX_W-1:0] disp_hex,
  output logic [SPR_W-1:0] disp_spr,
  output logic             busy,
  output logic [1:0]       src
);

  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS - 1);

  if (HOLD_TICKS < 1 || BLINK_TICKS < 1) begin : g_bad_param
    $error("display_scheduler: HOLD_TICKS and BLINK_TICKS must be >= 1");
  end

  disp_state_t state_q, state_d;
  disp_word_t  disp_q, disp_d;
  logic        err_ack_q, err_ack_d;
  logic        info_ack_q, info_ack_d;
  logic        busy_q, busy_d;
  logic [1:0]  src_q, src_d;
  logic        hold_load, hold_en, hold_zero;
  logic        accept_err;

  hold_timer #(.MAX_COUNT(HOLD_TICKS)) u_hold (
    .slow_clock (slow_clock),
    .RESET      (RESET),
    .load       (hold_load),
    .load_value (HOLD_LOAD),
    .enable     (hold_en),
    .zero       (hold_zero)
  );

`ifdef DISPLAY_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_TICKS - 1);

  logic       blink_load, blink_en, blink_zero;
  logic       phase_q, phase_d;
  disp_word_t err_word_q, err_word_d;

  hold_timer #(.MAX_COUNT(BLINK_TICKS)) u_blink (
    .slow_clock (slow_clock),
    .RESET      (RESET),
    .load       (blink_load),
    .load_value (BLINK_LOAD),
    .enable     (blink_en),
    .zero       (blink_zero)
  );
`endif

  // Next-state and output decode; an accepted error always reloads the hold timer.
  always_comb begin
    state_d    = state_q;
    disp_d     = '{hex: live_hex, spr: live_spr};
    err_ack_d  = 1'b0;
    info_ack_d = 1'b0;
    busy_d     = 1'b0;
    src_d      = SRC_LIVE;
    hold_load  = 1'b0;
    hold_en    = 1'b0;
    accept_err = 1'b0;
`ifdef DISPLAY_BLINK_EN
    blink_load = 1'b0;
    blink_en   = 1'b0;
    phase_d    = phase_q;
    err_word_d = err_word_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (err_req) begin
          accept_err = 1'b1;
        end else if (info_req) begin
          state_d    = SHOW_INFO;
          disp_d     = '{hex: info_hex, spr: info_spr};
          info_ack_d = 1'b1;
          busy_d     = 1'b1;
          src_d      = SRC_INFO;
          hold_load  = 1'b1;
        end
      end
      SHOW_INFO: begin
        if (err_req) begin
          accept_err = 1'b1;
        end else if (!hold_zero) begin
          hold_en = 1'b1;
          disp_d  = disp_q;
          busy_d  = 1'b1;
          src_d   = SRC_INFO;
        end else begin
          state_d = IDLE;
        end
      end
      SHOW_ERR: begin
        if (!hold_zero) begin
          hold_en = 1'b1;
          busy_d  = 1'b1;
          src_d   = SRC_ERR;
`ifdef DISPLAY_BLINK_EN
          blink_en   = 1'b1;
          blink_load = blink_zero;
          phase_d    = blink_zero ? ~phase_q : phase_q;
          if (!phase_d) disp_d = err_word_q;
`else
          disp_d = disp_q;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_err) begin
      state_d   = SHOW_ERR;
      disp_d    = '{hex: err_hex, spr: err_spr};
      err_ack_d = 1'b1;
      busy_d    = 1'b1;
      src_d     = SRC_ERR;
      hold_load = 1'b1;
`ifdef DISPLAY_BLINK_EN
      blink_load = 1'b1;
      phase_d    = 1'b0;
      err_word_d = '{hex: err_hex, spr: err_spr};
`endif
    end
  end

  always_ff @(posedge slow_clock) begin
    if (RESET) begin
      state_q    <= IDLE;
      disp_q     <= '0;
      err_ack_q  <= 1'b0;
      info_ack_q <= 1'b0;
      busy_q     <= 1'b0;
      src_q      <= SRC_LIVE;
    end else begin
      state_q    <= state_d;
      disp_q     <= disp_d;
      err_ack_q  <= err_ack_d;
      info_ack_q <= info_ack_d;
      busy_q     <= busy_d;
      src_q      <= src_d;
    end
  end

`ifdef DISPLAY_BLINK_EN
  always_ff @(posedge slow_clock) begin
    if (RESET) begin
      phase_q    <= 1'b0;
      err_word_q <= '0;
    end else begin
      phase_q    <= phase_d;
      err_word_q <= err_word_d;
    end
  end
`endif

  assign disp_hex = disp_q.hex;
  assign disp_spr = disp_q.spr;
  assign err_ack  = err_ack_q;
  assign info_ack = info_ack_q;
  assign busy     = busy_q;
  assign src      = src_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed self-checking bench for display_scheduler with HOLD_TICKS=4, BLINK_TICKS=2.
module tb_display_scheduler;

  logic       slow_clock = 1'b0;
  logic       RESET;
  logic [7:0] live_hex, err_hex, info_hex, disp_hex;
  logic [6:0] live_spr, err_spr, info_spr, disp_spr;
  logic       err_req, info_req, err_ack, info_ack, busy;
  logic [1:0] src;

  int n_checks = 0;
  int n_fail   = 0;

  display_scheduler #(.HOLD_TICKS(4), .BLINK_TICKS(2)) dut (
    .slow_clock (slow_clock),
    .RESET      (RESET),
    .live_hex   (live_hex),
    .live_spr   (live_spr),
    .err_req    (err_req),
    .err_hex    (err_hex),
    .err_spr    (err_spr),
    .err_ack    (err_ack),
    .info_req   (info_req),
    .info_hex   (info_hex),
    .info_spr   (info_spr),
    .info_ack   (info_ack),
    .disp_hex   (disp_hex),
    .disp_spr   (disp_spr),
    .busy       (busy),
    .src        (src)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic check_disp(input string tag, input logic [7:0] hx, input logic [6:0] sp,
                            input logic bz, input logic [1:0] sr);
    check_eq({tag, ".hex"},  32'(disp_hex), 32'(hx));
    check_eq({tag, ".spr"},  32'(disp_spr), 32'(sp));
    check_eq({tag, ".busy"}, 32'(busy), 32'(bz));
    check_eq({tag, ".src"},  32'(src), 32'(sr));
  endtask

  // Expected error display in cycle i of an error hold (blink pattern: P, P, L, L).
  function automatic logic err_shows_payload(input int i);
`ifdef DISPLAY_BLINK_EN
    return (i < 2);
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    live_hex = 8'h3C; live_spr = 7'h05;
    err_req = 1'b0; err_hex = 8'h00; err_spr = 7'h00;
    info_req = 1'b0; info_hex = 8'h00; info_spr = 7'h00;
    tick(); tick();
    check_disp("reset", 8'h00, 7'h00, 1'b0, 2'd0);
    check_eq("reset.err_ack", 32'(err_ack), 32'd0);
    check_eq("reset.info_ack", 32'(info_ack), 32'd0);

    // Live path, one cycle latency
    RESET = 1'b0;
    tick();
    check_disp("live", 8'h3C, 7'h05, 1'b0, 2'd0);

    // Single error pulse; payload changes after accept must be ignored
    err_req = 1'b1; err_hex = 8'hEE; err_spr = 7'h01;
    tick();
    check_eq("err.ack", 32'(err_ack), 32'd1);
    check_disp("err.c0", 8'hEE, 7'h01, 1'b1, 2'd2);
    err_req = 1'b0; err_hex = 8'h11; err_spr = 7'h22;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_eq("err.ack_low", 32'(err_ack), 32'd0);
      if (err_shows_payload(i)) check_disp($sformatf("err.c%0d", i), 8'hEE, 7'h01, 1'b1, 2'd2);
      else                      check_disp($sformatf("err.c%0d", i), 8'h3C, 7'h05, 1'b1, 2'd2);
    end
    tick();
    check_disp("err.expire", 8'h3C, 7'h05, 1'b0, 2'd0);

    // Simultaneous requests: error first, one live cycle, then info
    err_req = 1'b1; err_hex = 8'hEE; err_spr = 7'h01;
    info_req = 1'b1; info_hex = 8'h1A; info_spr = 7'h22;
    tick();
    check_eq("sim.err_ack", 32'(err_ack), 32'd1);
    check_eq("sim.info_ack0", 32'(info_ack), 32'd0);
    check_eq("sim.src0", 32'(src), 32'd2);
    err_req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_eq("sim.info_ack_err", 32'(info_ack), 32'd0);
      check_eq("sim.src_err", 32'(src), 32'd2);
    end
    tick();
    check_eq("sim.info_ack_gap", 32'(info_ack), 32'd0);
    check_disp("sim.gap", 8'h3C, 7'h05, 1'b0, 2'd0);
    tick();
    check_eq("sim.info_ack", 32'(info_ack), 32'd1);
    check_disp("sim.info0", 8'h1A, 7'h22, 1'b1, 2'd1);
    info_req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_disp("sim.info", 8'h1A, 7'h22, 1'b1, 2'd1);
      check_eq("sim.info_ack_low", 32'(info_ack), 32'd0);
    end
    tick();
    check_disp("sim.end", 8'h3C, 7'h05, 1'b0, 2'd0);

    // Pre-emption of info by error two cycles after info accept
    info_req = 1'b1; info_hex = 8'h1A; info_spr = 7'h22;
    tick();
    check_eq("pre.info_ack", 32'(info_ack), 32'd1);
    check_disp("pre.info0", 8'h1A, 7'h22, 1'b1, 2'd1);
    info_req = 1'b0;
    tick();
    check_disp("pre.info1", 8'h1A, 7'h22, 1'b1, 2'd1);
    err_req = 1'b1; err_hex = 8'hEE; err_spr = 7'h01;
    tick();
    check_eq("pre.err_ack", 32'(err_ack), 32'd1);
    check_disp("pre.err0", 8'hEE, 7'h01, 1'b1, 2'd2);
    err_req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_eq("pre.src_err", 32'(src), 32'd2);
    end
    tick();
    check_disp("pre.expire", 8'h3C, 7'h05, 1'b0, 2'd0);
    tick();
    check_disp("pre.no_reshow", 8'h3C, 7'h05, 1'b0, 2'd0);
    check_eq("pre.info_ack_none", 32'(info_ack), 32'd0);

    // Reset in cycle 2 of an error hold aborts it without an ack
    live_hex = 8'h5A; live_spr = 7'h33;
    err_req = 1'b1;
    tick();
    check_eq("rst.err_ack", 32'(err_ack), 32'd1);
    err_req = 1'b0;
    tick();
    check_eq("rst.src_before", 32'(src), 32'd2);
    RESET = 1'b1; err_req = 1'b1;
    tick();
    check_disp("rst.abort", 8'h00, 7'h00, 1'b0, 2'd0);
    check_eq("rst.no_ack", 32'(err_ack), 32'd0);
    RESET = 1'b0; err_req = 1'b0;
    tick();
    check_disp("rst.live", 8'h5A, 7'h33, 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
